// File: rtl/ps2_key_receiver_pkg.sv
// Shared types and set-2 scan-code constants for the PS/2 key receiver.
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_BAT  = 8'hAA;
    localparam logic [7:0] PS2_ACK  = 8'hFA;
    localparam logic [7:0] PS2_RSND = 8'hFE;

    // Keyboard housekeeping bytes that carry no key information.
    function automatic logic is_drop_code(input logic [7:0] b);
        return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_RSND) ||
               (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_key_receiver_if.sv
// Decoded key-event bundle: key_valid is a one-cycle strobe, no back-pressure;
// keyCode/press/extended are valid on the strobe cycle and held until the next one.
interface ps2_key_if;
    import ps2_pkg::*;

    logic [7:0] keyCode;
    logic       press;
    logic       extended;
    logic       key_valid;
    logic       frame_err;
    state_t     state;

    modport master (output keyCode, press, extended, key_valid, frame_err, state);
    modport slave  (input  keyCode, press, extended, key_valid, frame_err, state);

endinterface

// File: rtl/ps2_key_receiver_filter.sv
// Synchronises the raw PS/2 pins, de-glitches the clock and flags its falling edges.
module ps2_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic Clk,
    input  logic RESET,
    input  logic psClk,
    input  logic psData,
    output logic fall,
    output logic data_s
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          filt_clk;
    logic [CW-1:0] cnt;

    // cnt counts consecutive samples disagreeing with filt_clk; any agreement restarts it.
    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            filt_clk  <= 1'b1;
            cnt       <= '0;
            fall      <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], psClk};
            data_sync <= {data_sync[0], psData};
            fall      <= 1'b0;
            if (clk_sync[1] == filt_clk) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_sync[1];
                cnt      <= '0;
                fall     <= filt_clk;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign data_s = data_sync[1];

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: frame FSM with watchdog, then set-2 E0/F0 prefix decoding.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic      Clk,
    input  logic      RESET,
    input  logic      psClk,
    input  logic      psData,
    ps2_key_if.master key
);

    localparam int WW = $clog2(TIMEOUT_CYCLES);

    logic          fall, data_s;
    state_t        state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par_ok, par_ok_n;
    logic          byte_done, byte_done_n;
    logic          stop_err, stop_err_n;
    logic          timeout;
    logic [WW-1:0] wd_cnt;
    logic          ext_pend, brk_pend;
    logic [7:0]    code_q;
    logic          press_q, ext_q, valid_q, err_q;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .Clk    (Clk),
        .RESET  (RESET),
        .psClk  (psClk),
        .psData (psData),
        .fall   (fall),
        .data_s (data_s)
    );

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        par_ok_n    = par_ok;
        byte_done_n = 1'b0;
        stop_err_n  = 1'b0;
        timeout     = 1'b0;
        if (fall) begin
            case (state)
                IDLE: if (!data_s) begin
                    state_n   = DATA;
                    bit_cnt_n = 3'd0;
                end
                DATA: begin
                    shreg_n   = {data_s, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_ok_n = ^{shreg, data_s};
                    state_n  = STOP;
                end
                STOP: begin
                    if (data_s && par_ok) byte_done_n = 1'b1;
                    else                  stop_err_n  = 1'b1;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE && wd_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
            // A fall on the terminal cycle wins, so the timeout sits in the else branch.
            timeout = 1'b1;
            state_n = IDLE;
        end
    end

    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            par_ok    <= 1'b0;
            byte_done <= 1'b0;
            stop_err  <= 1'b0;
            wd_cnt    <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            par_ok    <= par_ok_n;
            byte_done <= byte_done_n;
            stop_err  <= stop_err_n;
            wd_cnt    <= (fall || state == IDLE) ? '0 : wd_cnt + 1'b1;
            err_q     <= stop_err | timeout;
        end
    end

    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            code_q   <= 8'h00;
            press_q  <= 1'b0;
            ext_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (byte_done) begin
                if (shreg == PS2_EXT) begin
                    ext_pend <= 1'b1;
                end else if (shreg == PS2_BRK) begin
                    brk_pend <= 1'b1;
                end else begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                    if (!is_drop_code(shreg)) begin
                        code_q  <= shreg;
                        press_q <= ~brk_pend;
                        ext_q   <= ext_pend;
                        valid_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign key.keyCode   = code_q;
    assign key.press     = press_q;
    assign key.extended  = ext_q;
    assign key.key_valid = valid_q;
    assign key.frame_err = err_q;
    assign key.state     = state;

endmodule

// File: doc/ps2_key_receiver.md
Name: ps2_key_receiver

Overview:
- Upstream input stage for the game core. Deserialises PS/2 keyboard frames, checks parity and stop bit, and applies set-2 prefix handling (E0 extended, F0 break).
- Presents one decoded key event per make or break: keyCode, press, extended, plus a one-cycle key_valid strobe.
- Feeds thegame (keyCode/press) and game_reset (keyCode) directly.

Parameters:
- FILTER_LEN, 4: consecutive equal synchronised psClk samples required before the filtered clock changes level.
- TIMEOUT_CYCLES, 50000: Clk cycles with no filtered falling edge before a partial frame is aborted (1 ms at 50 MHz).

Ports:
- Clk  in  1  system clock, 50 MHz.
- RESET  in  1  reset; asynchronous, active-low.
- psClk  in  1  raw PS/2 clock from the pin; asynchronous.
- psData  in  1  raw PS/2 data from the pin; asynchronous.
- keyCode  out  8  last decoded scan code, prefix bytes stripped.
- press  out  1  1 = make, 0 = break, for keyCode.
- extended  out  1  1 when keyCode was preceded by E0.
- key_valid  out  1  one-cycle pulse; keyCode, press and extended are updated on this cycle.
- frame_err  out  1  one-cycle pulse on a parity error, bad stop bit or timeout.

Behaviour:
- Reset: all outputs go to 0; FSM goes to IDLE; prefix flags and counters are cleared. Reset during a frame discards the partial frame with no pulse.
- Input synchronisation:
  - psClk and psData each pass through a 2-FF synchroniser.
  - filt_clk (reset value 1) takes a new level only after FILTER_LEN identical synchronised samples.
  - fall is a one-cycle pulse on a filtered 1->0 transition.
  - The data bit is the synchronised psData on the fall cycle.
- Frame FSM (states IDLE, DATA, PARITY, STOP), transitions on fall only:
  - IDLE: data=0 (start bit) -> DATA, bit_cnt=0. data=1 -> stay in IDLE, no error.
  - DATA: shift the bit into the byte LSB-first and increment bit_cnt. After the 8th bit -> PARITY.
  - PARITY: par_ok = XOR(byte, bit) == 1 (odd parity) -> STOP.
  - STOP: if bit=1 and par_ok, pulse byte_done; otherwise pulse frame_err and discard the byte. -> IDLE.
- Watchdog:
  - Counter clears on every fall and while in IDLE.
  - When not in IDLE and the counter reaches TIMEOUT_CYCLES-1 with no fall that cycle: -> IDLE, frame_err pulse.
  - A fall on the terminal cycle takes priority; no timeout occurs.
- Decoder, acting on byte_done:
  - 0xE0: set ext_pend.
  - 0xF0: set brk_pend.
  - 0xAA, 0xFA, 0xFE, 0x00, 0xFF: drop the byte, clear both flags, no strobe.
  - Any other byte: keyCode <= byte, press <= ~brk_pend, extended <= ext_pend; pulse key_valid; clear both flags.
  - Repeated E0 or F0 keeps the flag set (idempotent).
- Latency:
  - byte_done is registered 1 Clk after the fall cycle of the stop bit.
  - key_valid and frame_err (stop/parity case) are asserted 2 Clk after that fall cycle.
  - frame_err (timeout case) is asserted 1 Clk after the terminal count.
- Output holding: keyCode, press and extended hold their values between strobes. key_valid and frame_err never assert in the same cycle.
- Typematic repeat (repeated make codes) produces one strobe per code, each with press=1.

Decomposition:
- ps2_pkg holds:
  - state_t enum {IDLE, DATA, PARITY, STOP};
  - localparams PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_BAT=8'hAA, PS2_ACK=8'hFA, PS2_RSND=8'hFE.
- One sub-module, ps2_filter: synchroniser, FILTER_LEN glitch filter and falling-edge detector. Outputs fall and data_s.
- Frame FSM, watchdog and decoder live in ps2_key_receiver.

Test Plan:
- Bench setup: FILTER_LEN=4, TIMEOUT_CYCLES=200, PS/2 half-period 20 Clk.
- Make of 0x1D ('W'), correct parity -> one key_valid; keyCode=0x1D, press=1, extended=0; frame_err stays 0.
- Sequence F0,1D -> one key_valid only (at the 1D frame); keyCode=0x1D, press=0. Then E0,F0,75 -> keyCode=0x75, press=0, extended=1.
- Frame 0x1D sent with even parity, then with stop bit 0 -> frame_err pulses once each; no key_valid; keyCode unchanged.
- Start bit plus 3 data bits, then psClk held high for 250 Clk -> frame_err at ~200 Clk after the last fall. A following valid 0x29 frame decodes correctly (keyCode=0x29, press=1).
- 2-cycle low glitches injected on psClk during IDLE and DATA -> no bit is sampled; a 0x16 frame still decodes with press=1. Byte 0xAA -> no strobe.
- RESET driven low mid-DATA (after 4 bits), then released; send F0 then 0x1D -> outputs 0 during reset; no stale flags; result is a break of 0x1D.
